// File: rtl/add_result_fifo.sv
// add_result_fifo
//   Capture stage for the 4-bit carry-look-ahead adder. Each accepted result
//   {cout, s} is stored in a small synchronous FIFO and handed to the consumer
//   in order. A saturating counter tracks accepted results whose carry-out was
//   set (4-bit overflow events).
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   adder result on in_s/in_cout is valid
//   in_s       in   adder sum [3:0]
//   in_cout    in   adder carry-out
//   in_ready   out  FIFO not full
//   out_valid  out  FIFO not empty
//   out_data   out  head entry {cout, s}
//   out_ready  in   consumer takes the head this cycle
//   flush      in   synchronous clear of FIFO contents (wins over push/pop)
//   level      out  occupancy 0..DEPTH
//   ovf_cnt    out  saturating count of accepted pushes with in_cout=1
module add_result_fifo #(
    parameter int DEPTH = 4,
    parameter int OVF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_s,
    input  logic                     in_cout,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [4:0]               out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic [OVF_W-1:0]         ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [4:0]       mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic [OVF_W-1:0] ovf_q,    ovf_d;

    logic push;
    logic pop;
    logic wr_en;

    // Handshake flags come only from registered occupancy, never from the
    // opposite side's request, so there is no bypass or fall-through path.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem[rd_ptr_q];
    assign level     = level_q;
    assign ovf_cnt   = ovf_q;

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A flush swallows any same-cycle push, including its overflow count.
    assign wr_en = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // Saturate at all-ones rather than wrapping back to zero.
            if (push && in_cout && (ovf_q != '1)) begin
                ovf_d = ovf_q + OVF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is intentionally not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {in_cout, in_s};
        end
    end

endmodule

// File: tb/tb_add_result_fifo.sv
module tb_add_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_cout, out_ready, flush;
    logic [3:0] in_s;
    logic       in_ready, out_valid;
    logic [4:0] out_data;
    logic [2:0] level;
    logic [7:0] ovf_cnt;

    // Second instance with a narrow overflow counter for the saturation check.
    logic       in_valid2, in_cout2, out_ready2, flush2;
    logic [3:0] in_s2;
    logic       in_ready2, out_valid2;
    logic [4:0] out_data2;
    logic [2:0] level2;
    logic [1:0] ovf_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_result_fifo #(.DEPTH(DEPTH), .OVF_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_s(in_s), .in_cout(in_cout),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush), .level(level), .ovf_cnt(ovf_cnt)
    );

    add_result_fifo #(.DEPTH(DEPTH), .OVF_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_s(in_s2), .in_cout(in_cout2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2), .flush(flush2), .level(level2), .ovf_cnt(ovf_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       iv;
        logic [3:0] s;
        logic       c;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [4:0] e_d;
        int         e_lvl;
        int         e_ovf;
    } vec_t;

    vec_t tbl [15];

    // Reference model: plain queue plus overflow tally.
    logic [4:0] mq [$];
    int         movf;

    initial begin
        // Expected outputs are those seen just after the edge that consumes the row.
        tbl[0]  = '{1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1, 0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  0, 0};
        tbl[2]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd17, 1, 1};
        tbl[3]  = '{1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd17, 2, 2};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 1, 2};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  0, 2};
        tbl[6]  = '{1'b1, 4'd1,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  1, 2};
        tbl[7]  = '{1'b1, 4'd2,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  2, 2};
        tbl[8]  = '{1'b1, 4'd3,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  3, 2};
        tbl[9]  = '{1'b1, 4'd4,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  4, 2};
        tbl[10] = '{1'b1, 4'd5,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  4, 2};
        tbl[11] = '{1'b0, 4'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2,  3, 2};
        tbl[12] = '{1'b0, 4'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  2, 2};
        tbl[13] = '{1'b0, 4'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  1, 2};
        tbl[14] = '{1'b0, 4'd0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  0, 2};

        rst = 1'b1;
        in_valid = 0; in_s = 0; in_cout = 0; out_ready = 0; flush = 0;
        in_valid2 = 0; in_s2 = 0; in_cout2 = 0; out_ready2 = 0; flush2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_level", level, 0);
        chk("reset_ovf", ovf_cnt, 0);
        rst = 1'b0;

        // Table-driven directed vectors.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_s = tbl[i].s; in_cout = tbl[i].c;
            out_ready = tbl[i].ordy; flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("tbl%0d_ovf", i), ovf_cnt, tbl[i].e_ovf);
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_d);
        end

        // Streaming at level 2: simultaneous push and pop keep occupancy fixed.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1; in_s = 4'(i); in_cout = 0; out_ready = 0; flush = 0;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1; in_s = 4'(i + 2); in_cout = 0; out_ready = 1;
            chk($sformatf("stream%0d_head", i), out_data, i);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_level", i), level, 2);
        end

        // Flush at level 3 with a concurrent push (cout=1) and pop.
        @(negedge clk);
        in_valid = 1; in_s = 4'd12; in_cout = 0; out_ready = 0;
        @(posedge clk);
        #1;
        chk("preflush_level", level, 3);
        chk("preflush_head", out_data, 10);
        @(negedge clk);
        in_valid = 1; in_s = 4'd7; in_cout = 1; out_ready = 1; flush = 1;
        @(posedge clk);
        #1;
        chk("flush_level", level, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_ovf", ovf_cnt, 2);

        // Asynchronous reset mid-stream.
        @(negedge clk);
        flush = 0; in_valid = 1; in_s = 4'd9; in_cout = 1; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_s = 4'd3;
        @(posedge clk);
        #1;
        chk("prerst_level", level, 2);
        chk("prerst_ovf", ovf_cnt, 4);
        @(negedge clk);
        in_valid = 0; in_cout = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_ovf", ovf_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the queue model.
        mq.delete();
        movf = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int bias;
            bit iv, ordy, fl, cc;
            logic [3:0] ss;
            @(negedge clk);
            chk("rnd_level", level, mq.size());
            chk("rnd_in_ready", in_ready, mq.size() != DEPTH);
            chk("rnd_out_valid", out_valid, mq.size() != 0);
            chk("rnd_ovf", ovf_cnt, movf);
            if (mq.size() != 0) chk("rnd_out_data", out_data, mq[0]);
            bias = (cyc / 100) % 3;
            iv   = ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)));
            ordy = ($urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)));
            fl   = ($urandom_range(0, 39) == 0);
            cc   = $urandom_range(0, 1);
            ss   = 4'($urandom_range(0, 15));
            in_valid = iv; out_ready = ordy; flush = fl; in_cout = cc; in_s = ss;
            if (fl) begin
                mq.delete();
            end else begin
                bit can_push;
                can_push = (mq.size() < DEPTH);
                if (ordy && mq.size() > 0) void'(mq.pop_front());
                if (iv && can_push) begin
                    mq.push_back({cc, ss});
                    if (cc && movf < 255) movf++;
                end
            end
        end
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0;

        // Overflow counter saturation on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            @(negedge clk);
            in_valid2 = 1; in_s2 = 4'(i); in_cout2 = 1; out_ready2 = 1;
            @(posedge clk);
            #1;
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            chk($sformatf("sat%0d_ovf", i), ovf_cnt2, exp_cnt);
        end
        @(negedge clk);
        in_valid2 = 0; out_ready2 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
